// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, the receive-side companion to uart_tx.
// The rx pin is synchronized, each frame is located by its start bit,
// every bit is sampled at mid-bit, and the finished byte is held in an
// output register behind a valid/ready handshake. Framing errors
// (including a line break) and overruns are reported as one-cycle pulses.

module uart_rx #(
    parameter int CD_MAX   = 10416,
    parameter int CD_WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Last count value of a bit period and the half-period offset that
    // moves the sampling point from the start-bit edge to mid-bit.
    localparam logic [CD_WIDTH-1:0] CD_LAST = CD_WIDTH'(CD_MAX);
    localparam logic [CD_WIDTH-1:0] HALF    = CD_WIDTH'(CD_MAX / 2);

    // LINE_BREAK waits out a low line after a bad stop bit so a held-low
    // line reports one error instead of a stream of bogus frames.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LINE_BREAK
    } state_t;

    state_t                state;
    logic [CD_WIDTH-1:0]   cd_count;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  rx_meta;
    logic                  rx_s;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with bit timing, shifting, delivery handshake and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cd_count  <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Error flags are single-cycle pulses unless re-armed below.
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A consumer accepting the held byte frees the register; a
            // frame completing on this same edge may refill it below.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cd_count <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                START: begin
                    if (cd_count == HALF) begin
                        cd_count <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cd_count <= cd_count + 1'b1;
                    end
                end

                DATA: begin
                    if (cd_count == CD_LAST) begin
                        cd_count <= '0;
                        shift    <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= 3'd0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cd_count <= cd_count + 1'b1;
                    end
                end

                STOP: begin
                    if (cd_count == CD_LAST) begin
                        cd_count <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= LINE_BREAK;
                        end
                    end else begin
                        cd_count <= cd_count + 1'b1;
                    end
                end

                LINE_BREAK: begin
                    cd_count <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    cd_count <= '0;
                    bit_idx  <= 3'd0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a short bit period
// (16 cycles per bit). Frames are driven bit by bit on the rx line and the
// outputs are compared against hand-computed values.

`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CD_MAX  = 15;
    localparam int BIT_CYC = CD_MAX + 1;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int testsRun;
    int testsFailed;

    int         validCycles;
    int         frameErrCount;
    int         overrunCount;
    logic [7:0] acceptedBytes[$];

    int accBefore;
    int feBefore;
    int ovBefore;
    int vcBefore;

    uart_rx #(
        .CD_MAX  (CD_MAX),
        .CD_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe outputs on the falling edge: count pulses and record every
    // byte the consumer accepts on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) validCycles++;
            if (rx_valid && rx_ready) acceptedBytes.push_back(rx_data);
            if (frame_err) frameErrCount++;
            if (overrun) overrunCount++;
        end
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one 8N1 frame; call just after a rising edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (BIT_CYC) @(posedge clk);
            #1;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lastAccepted();
        if (acceptedBytes.size() == 0) return 32'hDEAD;
        return {24'h0, acceptedBytes[acceptedBytes.size() - 1]};
    endfunction

    task automatic snapshot();
        accBefore = acceptedBytes.size();
        feBefore  = frameErrCount;
        ovBefore  = overrunCount;
        vcBefore  = validCycles;
    endtask

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        validCycles   = 0;
        frameErrCount = 0;
        overrunCount  = 0;
        rx            = 1'b1;
        rx_ready      = 1'b1;
        rst_n         = 1'b0;

        idleCycles(3);
        @(negedge clk);
        checkOutput("reset_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("reset_data", {24'h0, rx_data}, 32'h00);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_ferr", {31'h0, frame_err}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycles(4);

        // Single frame with consumer always ready.
        snapshot();
        applyStimulus(8'h68, 1'b1);
        idleCycles(4);
        checkOutput("t1_count", acceptedBytes.size() - accBefore, 32'd1);
        checkOutput("t1_data", lastAccepted(), 32'h68);
        checkOutput("t1_valid_width", validCycles - vcBefore, 32'd1);
        checkOutput("t1_ferr", frameErrCount - feBefore, 32'd0);
        checkOutput("t1_overrun", overrunCount - ovBefore, 32'd0);
        checkOutput("t1_busy", {31'h0, busy}, 32'h0);

        // Consumer stalled: second back-to-back frame overruns.
        rx_ready = 1'b0;
        snapshot();
        applyStimulus(8'h41, 1'b1);
        checkOutput("t2_valid_first", {31'h0, rx_valid}, 32'h1);
        checkOutput("t2_data_first", {24'h0, rx_data}, 32'h41);
        applyStimulus(8'h5A, 1'b1);
        idleCycles(4);
        checkOutput("t2_overrun", overrunCount - ovBefore, 32'd1);
        checkOutput("t2_data_held", {24'h0, rx_data}, 32'h41);
        checkOutput("t2_valid_held", {31'h0, rx_valid}, 32'h1);
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t2_valid_drop", {31'h0, rx_valid}, 32'h0);
        checkOutput("t2_accepted", lastAccepted(), 32'h41);
        checkOutput("t2_accept_count", acceptedBytes.size() - accBefore, 32'd1);
        #1;

        // Ready asserted exactly on the second completion edge.
        idleCycles(2);
        rx_ready = 1'b0;
        snapshot();
        applyStimulus(8'h41, 1'b1);
        fork
            applyStimulus(8'h5A, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idleCycles(2);
        checkOutput("t3_data_new", {24'h0, rx_data}, 32'h5A);
        checkOutput("t3_valid", {31'h0, rx_valid}, 32'h1);
        checkOutput("t3_overrun", overrunCount - ovBefore, 32'd0);
        checkOutput("t3_took_old", lastAccepted(), 32'h41);
        rx_ready = 1'b1;
        idleCycles(2);
        checkOutput("t3_drain", lastAccepted(), 32'h5A);

        // Short low glitch aborts at mid start bit.
        snapshot();
        rx = 1'b0;
        idleCycles(4);
        rx = 1'b1;
        @(negedge clk);
        checkOutput("t4_busy_in_start", {31'h0, busy}, 32'h1);
        idleCycles(40);
        checkOutput("t4_busy_after", {31'h0, busy}, 32'h0);
        checkOutput("t4_valid", validCycles - vcBefore, 32'd0);
        checkOutput("t4_ferr", frameErrCount - feBefore, 32'd0);

        // Bad stop bit followed by a long break, then a good frame.
        snapshot();
        applyStimulus(8'h55, 1'b0);
        rx = 1'b0;
        idleCycles(40 * BIT_CYC);
        checkOutput("t5_busy_break", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        idleCycles(2 * BIT_CYC);
        checkOutput("t5_ferr_count", frameErrCount - feBefore, 32'd1);
        checkOutput("t5_no_byte", acceptedBytes.size() - accBefore, 32'd0);
        applyStimulus(8'hA3, 1'b1);
        idleCycles(4);
        checkOutput("t5_good_count", acceptedBytes.size() - accBefore, 32'd1);
        checkOutput("t5_good_data", lastAccepted(), 32'hA3);
        checkOutput("t5_ferr_total", frameErrCount - feBefore, 32'd1);

        // Reset in the middle of a frame abandons it.
        snapshot();
        fork
            applyStimulus(8'hFF, 1'b1);
            begin
                repeat (5 * BIT_CYC + 8) @(posedge clk);
                #1 rst_n = 1'b0;
                @(negedge clk);
                checkOutput("t6_rst_busy", {31'h0, busy}, 32'h0);
                checkOutput("t6_rst_data", {24'h0, rx_data}, 32'h00);
                checkOutput("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        idleCycles(BIT_CYC);
        checkOutput("t6_no_ff", acceptedBytes.size() - accBefore, 32'd0);
        applyStimulus(8'h0F, 1'b1);
        idleCycles(4);
        checkOutput("t6_count", acceptedBytes.size() - accBefore, 32'd1);
        checkOutput("t6_data", lastAccepted(), 32'h0F);
        checkOutput("t6_ferr", frameErrCount - feBefore, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
